// File: rtl/msp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msp_pkg
// Description : Shared types and helpers for multi_sample_player.
//               - ch_state_t  : per-channel playback state
//               - seq_state_t : mix sequencer state
//               - saturate()  : clamp a sign-extended value to an N-bit signed
//                               range. Callers sign-extend their source (of any
//                               width up to SAT_MAX_W) into SAT_MAX_W bits, so
//                               the same function serves any input width.
// Revision    : 1.0 - initial release
// ============================================================================
package msp_pkg;

  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_PLAY = 2'd1,
    CH_DONE = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_SCAN  = 2'd1,
    SEQ_DRAIN = 2'd2,
    SEQ_OUT   = 2'd3
  } seq_state_t;

  function automatic logic signed [SAT_MAX_W-1:0] saturate(
    input logic signed [SAT_MAX_W-1:0] value,
    input int                          out_w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msp_channel.sv
`default_nettype none
// ============================================================================
// Module      : msp_channel
// Description : One playback channel: state machine, sample pointer and the
//               active / contribute flags.
// Ports       : clk, reset (sync, active-high)
//               tick    - accepted sample tick (advance one step)
//               play    - level gate; low rewinds to IDLE
//               loop    - 1 = wrap at end of region, 0 = one-shot
//               ptr     - sample index to read for this tick
//               contrib - channel supplies a sample at this tick
//               active  - channel is currently producing samples
// Revision    : 1.0 - initial release
// ============================================================================
module msp_channel
  import msp_pkg::*;
#(
  parameter int DEPTH = 48000,
  parameter int PTR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             play,
  input  logic             loop,
  output logic [PTR_W-1:0] ptr,
  output logic             contrib,
  output logic             active
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  ch_state_t        state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             active_q, active_d;

  // The tick that starts playback already plays index 0 (ptr is 0 in IDLE),
  // so IDLE and PLAY share the advance path and a one-shot yields exactly
  // DEPTH samples.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    // Dropping play between ticks clears the active flag on the next clock.
    active_d = active_q & play;
    if (tick) begin
      if (!play) begin
        state_d = CH_IDLE;
        ptr_d   = '0;
      end else if (state_q != CH_DONE) begin
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = loop ? CH_PLAY : CH_DONE;
        end else begin
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = CH_PLAY;
        end
      end
      active_d = (state_d == CH_PLAY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CH_IDLE;
      ptr_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
    end
  end

  assign ptr     = ptr_q;
  assign contrib = play & (state_q != CH_DONE);
  assign active  = active_q;

endmodule
`default_nettype wire

// File: rtl/multi_sample_player.sv
`default_nettype none
// ============================================================================
// Module      : multi_sample_player
// Description : NUM_CH independent sample players sharing one external ROM,
//               mixed with saturation into a single signed audio word.
//               On each accepted 48 kHz tick the sequencer snapshots every
//               channel's (contrib, ptr), issues one ROM address per cycle and
//               accumulates the returned words; audio is registered
//               NUM_CH+2 cycles after the tick.
// Ports       : clk, reset (sync, active-high), clk_48KHz_en (sample tick)
//               play[NUM_CH], loop[NUM_CH]   - per-channel gate / mode
//               rom_addr / rom_data          - shared ROM, 1-cycle read
//               ch_active[NUM_CH]            - per-channel activity
//               audio                        - mixed, saturated output
//               volume[4*NUM_CH]             - per-channel gain (optional)
// Options     : SAMPLE_VOLUME_EN - adds the volume port; each contribution is
//               (sample*vol)>>>4 through a registered multiply, which adds one
//               cycle of audio latency.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_sample_player
  import msp_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 48000,
  parameter int ADDR_W   = $clog2(NUM_CH * DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_48KHz_en,
  input  logic [NUM_CH-1:0]          play,
  input  logic [NUM_CH-1:0]          loop,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [SAMPLE_W-1:0]        rom_data,
  output logic [NUM_CH-1:0]          ch_active,
`ifdef SAMPLE_VOLUME_EN
  input  logic [4*NUM_CH-1:0]        volume,
`endif
  output logic signed [SAMPLE_W-1:0] audio
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
`ifdef SAMPLE_VOLUME_EN
  localparam int ADD_LAT = 3;  // address, ROM read, multiply, then add
  localparam int PROD_W  = SAMPLE_W + 5;
`else
  localparam int ADD_LAT = 2;  // address, ROM read, then add
`endif
  // cnt value at which the last channel's term is accumulated
  localparam int LAST_ADD = NUM_CH + ADD_LAT - 1;
  localparam int CNT_W    = $clog2(LAST_ADD + 2) + 1;

  // ---------------------------------------------------------------- channels
  logic [NUM_CH-1:0] ch_contrib;
  logic [NUM_CH-1:0] ch_act;
  logic [PTR_W-1:0]  ch_ptr [NUM_CH];
  logic              tick_acc;

  seq_state_t seq_q, seq_d;

  // Ticks landing while a scan is in flight are dropped entirely.
  assign tick_acc = clk_48KHz_en && (seq_q == SEQ_IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    msp_channel #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick_acc),
      .play    (play[c]),
      .loop    (loop[c]),
      .ptr     (ch_ptr[c]),
      .contrib (ch_contrib[c]),
      .active  (ch_act[c])
    );
  end

  // --------------------------------------------------------------- sequencer
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0]        audio_q, audio_d;
  logic [ADDR_W-1:0]          rom_addr_q, rom_addr_d;
  logic [NUM_CH-1:0]          snap_contrib_q, snap_contrib_d;
  logic [PTR_W-1:0]           snap_ptr_q [NUM_CH];
  logic [PTR_W-1:0]           snap_ptr_d [NUM_CH];
  logic [CH_W-1:0]            issue_idx;
  logic [CH_W-1:0]            add_idx;
  logic signed [ACC_W-1:0]    add_term;
  logic                       busy;
`ifdef SAMPLE_VOLUME_EN
  logic [CH_W-1:0]            mul_idx;
  logic signed [PROD_W-1:0]   prod_full;
  logic signed [ACC_W-1:0]    prod_q, prod_d;
`endif

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [CH_W-1:0]  ch,
    input logic [PTR_W-1:0] p
  );
    return ADDR_W'(int'(ch) * DEPTH) + ADDR_W'(p);
  endfunction

  always_comb begin
    seq_d          = seq_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    audio_d        = audio_q;
    rom_addr_d     = rom_addr_q;
    snap_contrib_d = snap_contrib_q;
    snap_ptr_d     = snap_ptr_q;
    busy           = (seq_q == SEQ_SCAN) || (seq_q == SEQ_DRAIN);
    issue_idx      = CH_W'(cnt_q);
    add_idx        = CH_W'(cnt_q - CNT_W'(ADD_LAT));
`ifdef SAMPLE_VOLUME_EN
    // Multiply stage works on the word returned for channel cnt-2; the
    // product is added one cycle later.
    mul_idx   = CH_W'(cnt_q - CNT_W'(2));
    prod_full = PROD_W'($signed(rom_data)) *
                PROD_W'($signed({1'b0, volume[4*mul_idx +: 4]}));
    prod_d    = prod_q;
    if (busy && cnt_q >= CNT_W'(2) && cnt_q <= CNT_W'(NUM_CH + 1)) begin
      prod_d = snap_contrib_q[mul_idx] ? ACC_W'(prod_full >>> 4) : '0;
    end
    add_term = prod_q;
`else
    add_term = snap_contrib_q[add_idx] ? ACC_W'($signed(rom_data)) : '0;
`endif

    case (seq_q)
      SEQ_IDLE: begin
        if (clk_48KHz_en) begin
          // Channel 0 is addressed straight from the live pointer; the rest
          // come from the snapshot because the pointers advance this edge.
          snap_contrib_d = ch_contrib;
          snap_ptr_d     = ch_ptr;
          rom_addr_d     = addr_of('0, ch_ptr[0]);
          acc_d          = '0;
          cnt_d          = CNT_W'(1);
          seq_d          = (NUM_CH > 1) ? SEQ_SCAN : SEQ_DRAIN;
        end
      end
      SEQ_SCAN: begin
        rom_addr_d = addr_of(issue_idx, snap_ptr_q[issue_idx]);
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_CH - 1)) begin
          seq_d = SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_ADD)) begin
          seq_d = SEQ_OUT;
        end
      end
      SEQ_OUT: begin
        audio_d = SAMPLE_W'(saturate(SAT_MAX_W'(acc_q), SAMPLE_W));
        seq_d   = SEQ_IDLE;
      end
      default: seq_d = SEQ_IDLE;
    endcase

    // Accumulation overlaps the address issue once the pipeline has filled.
    if (busy && cnt_q >= CNT_W'(ADD_LAT)) begin
      acc_d = acc_q + add_term;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q          <= SEQ_IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      audio_q        <= '0;
      rom_addr_q     <= '0;
      snap_contrib_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_ptr_q[i] <= '0;
      end
`ifdef SAMPLE_VOLUME_EN
      prod_q         <= '0;
`endif
    end else begin
      seq_q          <= seq_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      audio_q        <= audio_d;
      rom_addr_q     <= rom_addr_d;
      snap_contrib_q <= snap_contrib_d;
      snap_ptr_q     <= snap_ptr_d;
`ifdef SAMPLE_VOLUME_EN
      prod_q         <= prod_d;
`endif
    end
  end

  assign rom_addr  = rom_addr_q;
  assign audio     = audio_q;
  assign ch_active = ch_act;

endmodule
`default_nettype wire

// File: doc/multi_sample_player.md
Name: multi_sample_player

Overview:
- Parametrised successor to the single-channel one-shot sample player.
- Plays NUM_CH independent sample regions from one shared, externally owned sample ROM.
- Each channel has its own play gate and one-shot/loop mode; all channels are mixed with saturation into one signed audio word at the 48 kHz rate.
- Sits between the sound-trigger latches and the audio output mux; the ROM is instantiated outside this block.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- SAMPLE_W, 16, sample and audio width, signed two's complement.
- DEPTH, 48000, samples per channel region; channel c occupies ROM words c*DEPTH .. c*DEPTH+DEPTH-1.
- ADDR_W, $clog2(NUM_CH*DEPTH), ROM address width.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- clk_48KHz_en, input, 1: one-cycle sample tick.
- play, input, NUM_CH: per-channel level gate; high = play, low = stop and rewind.
- loop, input, NUM_CH: per-channel mode; 1 = wrap at end of region, 0 = one-shot.
- rom_addr, output, ADDR_W: shared ROM read address.
- rom_data, input, SAMPLE_W: ROM data, valid exactly 1 cycle after rom_addr.
- ch_active, output, NUM_CH: channel is currently producing samples.
- audio, output, SAMPLE_W: mixed, saturated output, signed.

Behaviour:
- Reset: audio=0, rom_addr=0, ch_active=0, all pointers=0, all channels IDLE, sequencer IDLE. Reset mid-scan abandons the scan with no partial audio update.
- Per-channel FSM (advances only on an accepted tick; play and loop are sampled at that tick):
  - IDLE: if play=1, go to PLAY with ptr=0.
  - PLAY: contribute rom[base+ptr], then ptr++. At ptr=DEPTH-1: if loop=1, ptr becomes 0 and the channel stays in PLAY; if loop=0, go to DONE.
  - DONE: contributes 0 and ch_active=0.
  - In any state, play=0 at a tick forces IDLE, ptr=0, contribution 0.
  - play=0 asserted between ticks also clears ch_active on the next clk.
- One-shot length: exactly DEPTH samples per play assertion. Re-trigger requires play to drop and then rise again.
- Sequencer: on an accepted tick it scans channels 0..NUM_CH-1, issuing one rom_addr per cycle.
  - The scan snapshots each channel's contribution flag at the tick.
  - Each rom_data is added, one cycle later, into a signed accumulator of width SAMPLE_W+$clog2(NUM_CH)+1; non-contributing channels add 0.
- Output: after the last add, the sum is saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and registered into audio.
  - audio updates exactly NUM_CH+2 cycles after the tick.
  - audio holds its value between updates.
- Tick spacing: the integrator guarantees at least NUM_CH+3 cycles between ticks. A tick arriving while the sequencer is busy is ignored; no pointer advances for it.
- All channels IDLE or DONE: the scan still runs and audio becomes 0 at the normal latency.
- rom_addr is don't-care outside a scan but is held at its last value.

Optional Feature:
- Macro: SAMPLE_VOLUME_EN.
- When defined:
  - Adds input port volume, width 4*NUM_CH; nibble c is channel c's gain.
  - Channel c's contribution becomes (sample*vol_c)>>>4 with an arithmetic shift; vol=15 ≈ unity, vol=0 = mute.
  - The multiply is registered, so audio latency becomes NUM_CH+3 and the minimum tick spacing becomes NUM_CH+4.
- When not defined: no volume port, unity gain, latency as above.

Decomposition:
- Package msp_pkg holds:
  - ch_state_t enum {CH_IDLE, CH_PLAY, CH_DONE};
  - seq_state_t enum {SEQ_IDLE, SEQ_SCAN, SEQ_DRAIN, SEQ_OUT};
  - saturate function, parametrised by input width and SAMPLE_W.
- Sub-module msp_channel: one instance per channel, containing the FSM, pointer, and the active/contribute flag, instantiated via generate. The top level owns the sequencer, accumulator and saturation.

Test Plan:
- ROM word = channel*1000 + index (signed 16-bit); NUM_CH=2, DEPTH=8; play[0]=1 with loop=0; ticks every 10 clk -> audio = 0,1,...,7, then 0; ch_active[0] falls after the 8th tick; audio changes exactly 4 clk after each tick.
- Same ROM; loop[1]=1 and play[1] held for 20 ticks -> audio sequence 1000..1007 repeated; ch_active[1] stays 1 throughout.
- Both channels playing, ROM ch0=+30000, ch1=+10000 -> audio=32767; with ch0=-30000, ch1=-10000 -> audio=-32768.
- Drop play[0] after 3 ticks, reassert 2 ticks later -> the restarted sequence begins at index 0; an extra tick issued 2 clk after a tick is ignored, with pointers and audio unchanged by it.
- Assert reset mid-scan, 1 clk after a tick -> audio=0, ch_active=0, and the next tick after release starts a fresh scan.
- With SAMPLE_VOLUME_EN: vol0=8, sample=1000 -> audio=500; vol0=0 -> audio=0; audio changes 5 clk after the tick.
